// File: rtl/l2_ins_fetch_unit.sv
// Miss-fetch engine: queues L1 instruction miss addresses in order, issues one L2 block read
// at a time and holds each returned block until the L1 side accepts it.
module l2_ins_fetch_unit #(
  parameter int unsigned ADDRESS_WIDTH  = 32,
  parameter int unsigned BLOCK_WIDTH    = 512,
  parameter int unsigned WORD_PER_BLOCK = 16,
  parameter int unsigned QUEUE_DEPTH    = 4
) (
  input  logic                                                clk,
  input  logic                                                rst_n,
  input  logic                                                address_to_l2_valid_ins,
  output logic                                                address_to_l2_ready_ins,
  input  logic [ADDRESS_WIDTH-3:0]                            address_to_l2_ins,
  output logic                                                data_from_l2_valid_ins,
  input  logic                                                data_from_l2_ready_ins,
  output logic [BLOCK_WIDTH-1:0]                              data_from_l2_ins,
  output logic                                                l2_rd_req,
  output logic [ADDRESS_WIDTH-3-$clog2(WORD_PER_BLOCK):0]     l2_rd_addr,
  input  logic                                                l2_rd_ack,
  input  logic                                                l2_rd_data_valid,
  input  logic [BLOCK_WIDTH-1:0]                              l2_rd_data,
  output logic                                                busy,
  output logic                                                protocol_err
);

  localparam int unsigned WORD_SELECT = $clog2(WORD_PER_BLOCK);
  localparam int unsigned PTR_W       = $clog2(QUEUE_DEPTH);
  localparam int unsigned CNT_W       = PTR_W + 1;
  localparam int unsigned BLK_ADDR_W  = ADDRESS_WIDTH - 2 - WORD_SELECT;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [BLK_ADDR_W-1:0]   queue_mem [QUEUE_DEPTH];
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [CNT_W-1:0]        count;
  logic [CNT_W-1:0]        count_next;
  logic                    push;
  logic                    pop;
  logic                    load_data;
  logic                    valid_next;
  logic                    err_set;
  logic                    unused_word_bits;

  // Word-offset bits select nothing here: a miss always fetches the whole block.
  assign unused_word_bits = ^address_to_l2_ins[WORD_SELECT-1:0];

  assign address_to_l2_ready_ins = (count != CNT_W'(QUEUE_DEPTH));
  assign push      = address_to_l2_valid_ins && address_to_l2_ready_ins;
  assign l2_rd_req = (state == S_ISSUE);
  assign l2_rd_addr = (state == S_ISSUE) ? queue_mem[rd_ptr] : '0;
  assign busy      = (state != S_IDLE) || (count != '0);
  assign err_set   = l2_rd_data_valid && (state != S_WAIT);

  // Next state, pop and output-register controls.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    load_data  = 1'b0;
    valid_next = data_from_l2_valid_ins;
    case (state)
      S_IDLE: begin
        if (count != '0) state_next = S_ISSUE;
      end
      S_ISSUE: begin
        if (l2_rd_ack) begin
          pop        = 1'b1;
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (l2_rd_data_valid) begin
          load_data  = 1'b1;
          valid_next = 1'b1;
          state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (data_from_l2_ready_ins) begin
          valid_next = 1'b0;
          // No pop can happen in HOLD, so occupancy next cycle is count plus any push.
          state_next = ((count != '0) || push) ? S_ISSUE : S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + CNT_W'(1);
    else if (pop && !push) count_next = count - CNT_W'(1);
  end

  // Queue storage needs no reset: entries are only read while count covers them.
  always_ff @(posedge clk) begin
    if (push) queue_mem[wr_ptr] <= address_to_l2_ins[ADDRESS_WIDTH-3:WORD_SELECT];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                  <= S_IDLE;
      wr_ptr                 <= '0;
      rd_ptr                 <= '0;
      count                  <= '0;
      data_from_l2_valid_ins <= 1'b0;
      data_from_l2_ins       <= '0;
      protocol_err           <= 1'b0;
    end else begin
      state                  <= state_next;
      count                  <= count_next;
      data_from_l2_valid_ins <= valid_next;
      if (push)      wr_ptr           <= wr_ptr + PTR_W'(1);
      if (pop)       rd_ptr           <= rd_ptr + PTR_W'(1);
      if (load_data) data_from_l2_ins <= l2_rd_data;
      if (err_set)   protocol_err     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_l2_ins_fetch_unit.sv
// Bench for l2_ins_fetch_unit: directed scenarios plus randomized traffic checked against an
// in-order transaction model (pending-address queue, one outstanding read, one held block).
module tb_l2_ins_fetch_unit;

  logic         clk;
  logic         rst_n;
  logic         a_valid;
  logic         a_ready;
  logic [29:0]  a_addr;
  logic         d_valid;
  logic         d_ready;
  logic [511:0] d_data;
  logic         l2_req;
  logic [25:0]  l2_addr;
  logic         l2_ack;
  logic         l2_dv;
  logic [511:0] l2_data;
  logic         busy;
  logic         perr;

  int checks;
  int failures;

  logic [25:0]  mq[$];
  bit           outstanding;
  bit           pending;
  logic [511:0] l1_exp;
  logic         exp_err;
  int           push_budget;
  int           accepted;

  l2_ins_fetch_unit dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .address_to_l2_valid_ins (a_valid),
    .address_to_l2_ready_ins (a_ready),
    .address_to_l2_ins       (a_addr),
    .data_from_l2_valid_ins  (d_valid),
    .data_from_l2_ready_ins  (d_ready),
    .data_from_l2_ins        (d_data),
    .l2_rd_req               (l2_req),
    .l2_rd_addr              (l2_addr),
    .l2_rd_ack               (l2_ack),
    .l2_rd_data_valid        (l2_dv),
    .l2_rd_data              (l2_data),
    .busy                    (busy),
    .protocol_err            (perr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [511:0] rand_blk();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    a_valid = 1'b0;
    a_addr  = '0;
    d_ready = 1'b0;
    l2_ack  = 1'b0;
    l2_dv   = 1'b0;
    l2_data = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    mq.delete();
    outstanding = 0;
    pending     = 0;
    exp_err     = 1'b0;
    push_budget = 0;
    accepted    = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
  endtask

  // One cycle of model-checked traffic; arguments are percent probabilities.
  task automatic tick(input int pp, input int pa, input int pd, input int pr);
    bit do_push, do_pop, do_acc;
    logic [511:0] blk;
    checks++;
    if (a_ready !== (mq.size() < 4)) begin
      failures++;
      $display("FAIL tick_ready: got %b expected %b (model depth %0d)", a_ready, mq.size() < 4, mq.size());
    end
    checks++;
    if (busy !== (mq.size() != 0 || outstanding || pending)) begin
      failures++;
      $display("FAIL tick_busy: got %b expected %b", busy, (mq.size() != 0 || outstanding || pending));
    end
    checks++;
    if (d_valid !== pending) begin
      failures++;
      $display("FAIL tick_dvalid: got %b expected %b", d_valid, pending);
    end
    if (pending) begin
      checks++;
      if (d_data !== l1_exp) begin
        failures++;
        $display("FAIL tick_data: got %h expected %h", d_data, l1_exp);
      end
    end
    if (l2_req === 1'b1) begin
      checks++;
      if (outstanding || pending || mq.size() == 0) begin
        failures++;
        $display("FAIL tick_req_extra: got req=1 expected 0 (outstanding=%0d held=%0d depth=%0d)",
                 outstanding, pending, mq.size());
      end else if (l2_addr !== mq[0]) begin
        failures++;
        $display("FAIL tick_req_addr: got %h expected %h", l2_addr, mq[0]);
      end
    end
    checks++;
    if (perr !== exp_err) begin
      failures++;
      $display("FAIL tick_perr: got %b expected %b", perr, exp_err);
    end
    a_valid = (push_budget > 0) && (int'($urandom_range(99)) < pp);
    a_addr  = 30'($urandom);
    l2_ack  = int'($urandom_range(99)) < pa;
    l2_dv   = outstanding && (int'($urandom_range(99)) < pd);
    blk     = rand_blk();
    l2_data = blk;
    d_ready = int'($urandom_range(99)) < pr;
    do_push = a_valid && a_ready;
    do_pop  = l2_req && l2_ack;
    do_acc  = d_valid && d_ready;
    if (do_acc) begin
      pending = 0;
      accepted++;
    end
    if (do_pop && mq.size() != 0) begin
      void'(mq.pop_front());
      outstanding = 1;
    end
    if (do_push) begin
      mq.push_back(a_addr[29:4]);
      push_budget--;
    end
    if (l2_dv) begin
      outstanding = 0;
      pending     = 1;
      l1_exp      = blk;
    end
    step();
  endtask

  task automatic drain();
    int n;
    push_budget = 0;
    n = 0;
    while ((mq.size() != 0 || outstanding || pending) && n < 300) begin
      tick(0, 100, 100, 100);
      n++;
    end
    checks++;
    if (mq.size() != 0 || outstanding || pending) begin
      failures++;
      $display("FAIL drain_timeout: got %0d entries still pending expected 0", mq.size());
    end
    clear_inputs();
    tick(0, 0, 0, 0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    #3;
    checks++;
    if ({d_valid, l2_req, busy, perr} !== 4'b0000 || d_data !== '0 || l2_addr !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got v=%b req=%b busy=%b err=%b addr=%h expected all 0",
               d_valid, l2_req, busy, perr, l2_addr);
    end
    do_reset();
    checks++;
    if (a_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready: got ready=%b busy=%b expected ready=1 busy=0", a_ready, busy);
    end
  endtask

  task automatic test_single();
    logic [511:0] blk;
    int pulses;
    do_reset();
    d_ready = 1'b1;
    a_valid = 1'b1;
    a_addr  = 30'h123;
    step();
    a_valid = 1'b0;
    checks++;
    if (l2_req !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL single_idle: got req=%b busy=%b expected req=0 busy=1", l2_req, busy);
    end
    step();
    checks++;
    if (l2_req !== 1'b1 || l2_addr !== 26'h12) begin
      failures++;
      $display("FAIL single_issue: got req=%b addr=%h expected req=1 addr=012", l2_req, l2_addr);
    end
    l2_ack = 1'b1;
    step();
    l2_ack = 1'b0;
    checks++;
    if (l2_req !== 1'b0 || d_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_wait: got req=%b v=%b expected 0 0", l2_req, d_valid);
    end
    step();
    step();
    blk     = rand_blk();
    l2_dv   = 1'b1;
    l2_data = blk;
    step();
    l2_dv = 1'b0;
    checks++;
    if (d_valid !== 1'b1 || d_data !== blk) begin
      failures++;
      $display("FAIL single_data: got v=%b data=%h expected v=1 data=%h", d_valid, d_data, blk);
    end
    pulses = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (d_valid === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL single_done: got pulses=%0d busy=%b expected pulses=1 busy=0", pulses, busy);
    end
    clear_inputs();
  endtask

  task automatic test_fill();
    do_reset();
    push_budget = 5;
    repeat (8) tick(100, 0, 0, 100);
    checks++;
    if (a_ready !== 1'b0 || push_budget != 1) begin
      failures++;
      $display("FAIL fill_full: got ready=%b unpushed=%0d expected ready=0 unpushed=1", a_ready, push_budget);
    end
    for (int i = 0; i < 60 && push_budget > 0; i++) tick(100, 100, 100, 100);
    drain();
    checks++;
    if (accepted != 5) begin
      failures++;
      $display("FAIL fill_blocks: got %0d blocks expected 5", accepted);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    push_budget = 2;
    for (int i = 0; i < 50 && !pending; i++) tick(100, 100, 100, 0);
    checks++;
    if (!pending) begin
      failures++;
      $display("FAIL bp_reach_hold: got no block expected a held block");
    end
    repeat (10) tick(100, 100, 100, 0);
    checks++;
    if (accepted != 0 || d_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_held: got accepted=%0d v=%b expected 0 1", accepted, d_valid);
    end
    drain();
  endtask

  task automatic test_push_pop();
    do_reset();
    push_budget = 3;
    repeat (3) tick(100, 0, 0, 100);
    tick(0, 0, 0, 100);
    checks++;
    if (l2_req !== 1'b1) begin
      failures++;
      $display("FAIL pp_issue: got req=%b expected 1", l2_req);
    end
    push_budget = 1;
    tick(100, 100, 0, 100);
    checks++;
    if (a_ready !== 1'b1 || mq.size() != 3) begin
      failures++;
      $display("FAIL pp_count: got ready=%b depth=%0d expected ready=1 depth=3", a_ready, mq.size());
    end
    push_budget = 1;
    tick(100, 0, 0, 100);
    checks++;
    if (a_ready !== 1'b0) begin
      failures++;
      $display("FAIL pp_full_after: got ready=%b expected 0", a_ready);
    end
    drain();
  endtask

  task automatic test_random();
    do_reset();
    push_budget = 80;
    repeat (400) tick(60, 50, 40, 60);
    drain();
  endtask

  task automatic test_spurious();
    do_reset();
    l2_dv   = 1'b1;
    l2_data = rand_blk();
    step();
    l2_dv = 1'b0;
    checks++;
    if (perr !== 1'b1 || d_valid !== 1'b0 || busy !== 1'b0 || l2_req !== 1'b0) begin
      failures++;
      $display("FAIL spurious: got err=%b v=%b busy=%b req=%b expected 1 0 0 0", perr, d_valid, busy, l2_req);
    end
    repeat (3) step();
    checks++;
    if (perr !== 1'b1) begin
      failures++;
      $display("FAIL spurious_sticky: got err=%b expected 1", perr);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    push_budget = 3;
    for (int i = 0; i < 20 && !(outstanding && mq.size() == 2); i++) tick(100, 100, 0, 100);
    checks++;
    if (!(outstanding && mq.size() == 2) || busy !== 1'b1) begin
      failures++;
      $display("FAIL rm_setup: got depth=%0d busy=%b expected depth=2 busy=1", mq.size(), busy);
    end
    clear_inputs();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({d_valid, l2_req, busy, perr, a_ready} !== 5'b00001 || l2_addr !== '0) begin
      failures++;
      $display("FAIL rm_async: got v=%b req=%b busy=%b err=%b ready=%b expected 0 0 0 0 1",
               d_valid, l2_req, busy, perr, a_ready);
    end
    step();
    rst_n = 1'b1;
    mq.delete();
    outstanding = 0;
    step();
    step();
    checks++;
    if (a_ready !== 1'b1 || busy !== 1'b0 || l2_req !== 1'b0) begin
      failures++;
      $display("FAIL rm_after: got ready=%b busy=%b req=%b expected 1 0 0", a_ready, busy, l2_req);
    end
    l2_dv   = 1'b1;
    l2_data = rand_blk();
    step();
    l2_dv = 1'b0;
    checks++;
    if (perr !== 1'b1 || d_valid !== 1'b0) begin
      failures++;
      $display("FAIL rm_late_data: got err=%b v=%b expected 1 0", perr, d_valid);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    clear_inputs();
    test_reset();
    test_single();
    test_fill();
    test_backpressure();
    test_push_pop();
    test_random();
    test_spurious();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
